// File: rtl/mskaes_cipher_unloader_if.sv
// Handshake/bus bundle between the masked AES core output, the unloader and the host word port.
// slave = unloader side, master = core/host side.
interface mskaes_cipher_unloader_if #(
  parameter int unsigned D = 2
);
  localparam int unsigned SW = $clog2(D);
  localparam int unsigned PW = 128 * D;

  logic          cipher_valid;
  logic          out_ready;
  logic [PW-1:0] sh_ciphertext;
  logic          flush;
  logic [31:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [SW-1:0] dout_share;
  logic          dout_last;
  logic          busy;

  modport slave (
    input  cipher_valid, sh_ciphertext, flush, dout_ready,
    output out_ready, dout, dout_valid, dout_share, dout_last, busy
  );

  modport master (
    output cipher_valid, sh_ciphertext, flush, dout_ready,
    input  out_ready, dout, dout_valid, dout_share, dout_last, busy
  );
endinterface

// File: rtl/mskaes_cipher_unloader.sv
// Captures d interleaved ciphertext shares in one cycle and streams them share-major as 32-bit
// words; shares are never recombined and the buffer is wiped once the block leaves or is flushed.
module mskaes_cipher_unloader #(
  parameter int unsigned D = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  mskaes_cipher_unloader_if.slave bus
);
  localparam int unsigned NW = 4 * D;
  localparam int unsigned CW = $clog2(NW);
  localparam int unsigned SW = $clog2(D);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [D-1:0][127:0] r_buf;
  logic [D-1:0][127:0] w_buf_nxt;
  logic [D-1:0][127:0] w_deint;
  logic [31:0]         r_dout;
  logic [31:0]         w_dout_nxt;
  logic [SW-1:0]       r_share;
  logic [SW-1:0]       w_share_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic [SW-1:0]       w_sh_sel;
  logic [1:0]          w_k_sel;
  logic [127:0]        w_sel;

  // Undo the core's bit interleave: bit i of share j sits at d*i+j.
  always_comb begin
    w_deint = '0;
    for (int unsigned j = 0; j < D; j++) begin
      for (int unsigned i = 0; i < 128; i++) begin
        w_deint[j][i] = bus.sh_ciphertext[D*i + j];
      end
    end
  end

  // Next state, word counter and buffer; flush outranks both capture and handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    case (r_state)
      ST_IDLE: begin
        if (bus.cipher_valid && !bus.flush) begin
          w_buf_nxt   = w_deint;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.flush || (bus.dout_ready && (r_cnt == CW'(NW - 1)))) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (bus.dout_ready) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_buf_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Word presented next cycle is selected here so dout leaves a flop.
    w_sh_sel    = SW'(w_cnt_nxt >> 2);
    w_k_sel     = w_cnt_nxt[1:0];
    w_sel       = w_buf_nxt[w_sh_sel];
    w_dout_nxt  = '0;
    w_share_nxt = '0;
    w_last_nxt  = 1'b0;
    if (w_state_nxt == ST_SEND) begin
      w_dout_nxt  = w_sel[{w_k_sel, 5'b0} +: 32];
      w_share_nxt = w_sh_sel;
      w_last_nxt  = (w_cnt_nxt == CW'(NW - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_dout  <= '0;
      r_share <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
      r_dout  <= w_dout_nxt;
      r_share <= w_share_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign bus.out_ready  = (r_state == ST_IDLE);
  assign bus.dout_valid = (r_state == ST_SEND);
  assign bus.busy       = (r_state == ST_SEND);
  assign bus.dout       = r_dout;
  assign bus.dout_share = r_share;
  assign bus.dout_last  = r_last;
endmodule

// File: tb/tb_mskaes_cipher_unloader.sv
// Bench for mskaes_cipher_unloader: queue-based reference for a d=2 instance plus a directed
// d=3 instance for share ordering and back-to-back block spacing.
module tb_mskaes_cipher_unloader;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mskaes_cipher_unloader_if #(.D(2)) bus ();
  mskaes_cipher_unloader_if #(.D(3)) bus3 ();

  mskaes_cipher_unloader #(.D(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mskaes_cipher_unloader #(.D(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  function automatic logic [383:0] ilv(input logic [2:0][127:0] s, input int d);
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < d; j++)
        r[d*i + j] = s[j][i];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: the block becomes a list of expected words, consumed one per accepted handshake.
  typedef struct {
    logic [31:0] w;
    int          sh;
    bit          last;
  } exp_t;

  exp_t             m_q[$];
  bit               m_busy = 1'b0;
  int               m_ncap = 0;
  int               m_nrst = 0;
  logic [2:0][127:0] tb_sh = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_busy = 1'b0;
      m_nrst++;
    end else if (!m_busy) begin
      if (bus.cipher_valid && !bus.flush) begin
        for (int j = 0; j < 2; j++) begin
          for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.w    = tb_sh[j][32*k +: 32];
            e.sh   = j;
            e.last = (j == 1) && (k == 3);
            m_q.push_back(e);
          end
        end
        m_busy = 1'b1;
        m_ncap++;
      end
    end else if (bus.flush) begin
      m_q.delete();
      m_busy = 1'b0;
    end else if (bus.dout_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_busy = 1'b0;
    end
  end

  logic [31:0] obs[$];
  bit          p_stall = 1'b0;
  logic [31:0] p_dout  = '0;
  int          p_nrst  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_ready", 32'(bus.out_ready), 32'(!m_busy));
      check("dout_valid", 32'(bus.dout_valid), 32'(m_busy));
      check("busy", 32'(bus.busy), 32'(m_busy));
      if (m_busy) begin
        check("dout", bus.dout, m_q[0].w);
        check("dout_share", 32'(bus.dout_share), 32'(m_q[0].sh));
        check("dout_last", 32'(bus.dout_last), 32'(m_q[0].last));
      end else begin
        check("dout_idle_zero", bus.dout, 32'h0);
        check("share_idle_zero", 32'(bus.dout_share), 32'h0);
        check("last_idle_zero", 32'(bus.dout_last), 32'h0);
      end
      if (p_stall && (p_nrst == m_nrst)) check("stall_hold", bus.dout, p_dout);
      p_stall = bus.dout_valid && !bus.dout_ready && !bus.flush;
      p_dout  = bus.dout;
      p_nrst  = m_nrst;
      if (bus.dout_valid && bus.dout_ready && !bus.flush) obs.push_back(bus.dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load2(input logic [2:0][127:0] s);
    logic [383:0] t;
    tb_sh = s;
    t = ilv(s, 2);
    bus.sh_ciphertext = t[255:0];
  endtask

  task automatic present(output int n);
    int snap;
    snap = m_ncap;
    n = 0;
    bus.cipher_valid = 1'b1;
    while ((m_ncap == snap) && (n < 200)) begin
      tick();
      n++;
    end
    if (m_ncap == snap) timeout("capture");
    bus.cipher_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && (n < 300)) begin
      tick();
      n++;
    end
    if (m_busy) timeout("drain");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0][127:0] sa;
    logic [2:0][127:0] sb;
    logic [383:0]      t;
    logic [31:0]       t1w[4];
    logic [31:0]       cw[4];
    logic [127:0]      c_x;
    logic [3:0]        pat;
    int                n;
    int                base;
    int                snap;
    bit                held;

    t1w = '{32'h76543210, 32'hfedcba98, 32'h89abcdef, 32'h01234567};
    cw  = '{32'h4b496089, 32'heafc4990, 32'h516745bf, 32'h8ea2b7ca};
    c_x = 128'h8ea2b7ca_516745bf_eafc4990_4b496089;
    pat = 4'b1001;

    bus.cipher_valid   = 1'b0;
    bus.sh_ciphertext  = '0;
    bus.flush          = 1'b0;
    bus.dout_ready     = 1'b0;
    bus3.cipher_valid  = 1'b0;
    bus3.sh_ciphertext = '0;
    bus3.flush         = 1'b0;
    bus3.dout_ready    = 1'b0;

    #12 rst_n = 1'b1;
    #1;
    check("rst_out_ready", 32'(bus.out_ready), 32'h1);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_share", 32'(bus.dout_share), 32'h0);
    check("rst_last", 32'(bus.dout_last), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // Known share 0, zero share 1.
    sa = '0;
    sa[0] = 128'h0123456789abcdef_fedcba9876543210;
    bus.dout_ready = 1'b1;
    load2(sa);
    base = obs.size();
    present(n);
    check("t1_first_valid", 32'(bus.dout_valid), 32'h1);
    check("t1_first_word", bus.dout, 32'h76543210);
    wait_idle();
    check("t1_count", 32'(obs.size() - base), 32'd8);
    for (int k = 0; k < 4; k++) begin
      check("t1_word", obs[base + k], t1w[k]);
      check("t1_xor", obs[base + k] ^ obs[base + 4 + k], t1w[k]);
    end
    check("t1_out_ready_back", 32'(bus.out_ready), 32'h1);

    // Random masking of a fixed value.
    sb = '0;
    sb[1] = rand128();
    sb[0] = sb[1] ^ c_x;
    load2(sb);
    base = obs.size();
    present(n);
    wait_idle();
    check("t2_count", 32'(obs.size() - base), 32'd8);
    for (int k = 0; k < 4; k++) check("t2_xor", obs[base + k] ^ obs[base + 4 + k], cw[k]);

    // Backpressure 1,0,0,1 with the next ciphertext already held by the core.
    sa = '0;
    sa[0] = rand128();
    sa[1] = rand128();
    sb = '0;
    sb[0] = rand128();
    sb[1] = rand128();
    base = obs.size();
    load2(sa);
    present(n);
    load2(sb);
    bus.cipher_valid = 1'b1;
    snap = m_ncap;
    held = 1'b1;
    for (int i = 0; (i < 300) && (held || m_busy); i++) begin
      bus.dout_ready = pat[i % 4];
      tick();
      if (held && (m_ncap != snap)) begin
        held = 1'b0;
        bus.cipher_valid = 1'b0;
        check("bp_accept_after_drain", 32'(obs.size() - base), 32'd8);
      end
    end
    if (held || m_busy) timeout("backpressure");
    bus.dout_ready = 1'b1;
    check("bp_count", 32'(obs.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < 8) check("bp_word_a", obs[base + i], sa[i / 4][32*(i % 4) +: 32]);
      else check("bp_word_b", obs[base + i], sb[(i - 8) / 4][32*(i % 4) +: 32]);
    end

    // Flush while the third word is on the port.
    sa[0] = rand128();
    sa[1] = rand128();
    load2(sa);
    present(n);
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", 32'(bus.dout_valid), 32'h0);
    check("flush_out_ready", 32'(bus.out_ready), 32'h1);
    check("flush_buf_zero", 32'(|dut.r_buf), 32'h0);
    present(n);
    check("flush_recapture_cycles", 32'(n), 32'd1);
    check("flush_recapture_busy", 32'(bus.busy), 32'h1);
    wait_idle();

    // Flush in IDLE blocks the capture for that cycle only.
    sa[0] = rand128();
    load2(sa);
    bus.cipher_valid = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("idle_flush_out_ready", 32'(bus.out_ready), 32'h1);
    check("idle_flush_busy", 32'(bus.busy), 32'h0);
    present(n);
    check("idle_flush_retry_cycles", 32'(n), 32'd1);
    wait_idle();

    // Random traffic, backpressure and occasional flush.
    snap = m_ncap;
    for (int c = 0; c < 800; c++) begin
      if (bus.cipher_valid && (m_ncap != snap)) bus.cipher_valid = 1'b0;
      if (!bus.cipher_valid && (($urandom % 4) == 0)) begin
        sa[0] = rand128();
        sa[1] = rand128();
        load2(sa);
        bus.cipher_valid = 1'b1;
        snap = m_ncap;
      end
      bus.dout_ready = (($urandom % 4) != 0);
      bus.flush = (($urandom % 40) == 0);
      tick();
    end
    bus.cipher_valid = 1'b0;
    bus.flush = 1'b0;
    bus.dout_ready = 1'b1;
    wait_idle();

    // Asynchronous reset pulse mid-stream, then a full restart.
    sa[0] = rand128();
    sa[1] = rand128();
    load2(sa);
    present(n);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("amid_out_ready", 32'(bus.out_ready), 32'h1);
    check("amid_dout_valid", 32'(bus.dout_valid), 32'h0);
    check("amid_dout", bus.dout, 32'h0);
    check("amid_busy", 32'(bus.busy), 32'h0);
    check("amid_last", 32'(bus.dout_last), 32'h0);
    check("amid_buf_zero", 32'(|dut.r_buf), 32'h0);
    rst_n = 1'b1;
    tick();
    base = obs.size();
    present(n);
    wait_idle();
    check("restart_count", 32'(obs.size() - base), 32'd8);
    check("restart_last_word", obs[base + 7], sa[1][127:96]);

    // d=3: share sequence and one IDLE cycle between held back-to-back blocks.
    sa[0] = rand128();
    sa[1] = rand128();
    sa[2] = rand128();
    sb[0] = rand128();
    sb[1] = rand128();
    sb[2] = rand128();
    t = ilv(sa, 3);
    bus3.sh_ciphertext = t;
    bus3.dout_ready = 1'b1;
    bus3.cipher_valid = 1'b1;
    tick();
    for (int s = 0; s < 26; s++) begin
      bit ev;
      int idx;
      logic [31:0] ew;
      @(negedge clk);
      ev  = !((s == 12) || (s == 25));
      idx = (s < 12) ? s : s - 13;
      check("d3_valid", 32'(bus3.dout_valid), 32'(ev));
      check("d3_out_ready", 32'(bus3.out_ready), 32'(!ev));
      if (ev) begin
        ew = (s < 12) ? sa[idx / 4][32*(idx % 4) +: 32] : sb[idx / 4][32*(idx % 4) +: 32];
        check("d3_share", 32'(bus3.dout_share), 32'(idx / 4));
        check("d3_word", bus3.dout, ew);
        check("d3_last", 32'(bus3.dout_last), 32'(idx == 11));
      end else begin
        check("d3_idle_dout", bus3.dout, 32'h0);
      end
      if (s == 0) begin
        t = ilv(sb, 3);
        bus3.sh_ciphertext = t;
      end
    end
    bus3.cipher_valid = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
